// File: rtl/scan_test_ctrl.sv
// Scan test sequencer for a single mux-D scan chain.
// Loads each stimulus vector MSB first, runs functional capture, and compares
// the shifted-out response of the previous vector against its expected value
// while the next vector is loaded. The final vector is unloaded with zeros.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start, chain frozen
// FETCH   | pat_ready high, waiting for the next vector, chain frozen
// SHIFT   | CHAIN_LEN shift cycles: load new vector, unload previous one
// CAPTURE | CAP_CYCLES functional cycles with scan_en low
// UNLOAD  | CHAIN_LEN shift cycles of zeros to unload the final response
// DONE    | one-cycle done pulse, then back to IDLE
module scan_test_ctrl #(
    parameter int CHAIN_LEN  = 5,
    parameter int CAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] exp_data,
    input  logic                 pat_last,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 chain_ce,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_W-1:0]     pat_count,
    output logic [CNT_W-1:0]     fail_count
);

    // One down-counter serves both the shift phases and the capture phase.
    localparam int MAX_LEN = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
    localparam int CW      = $clog2(MAX_LEN);
    localparam logic [CW-1:0]    SHIFT_LOAD = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0]    CAP_LOAD   = CW'(CAP_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CTR_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [CHAIN_LEN-1:0] stim_sr, stim_nxt;
    logic [CHAIN_LEN-1:0] exp_cur, exp_cur_nxt;
    logic [CHAIN_LEN-1:0] exp_prev, exp_prev_nxt;
    logic                 last, last_nxt;
    logic                 have_resp, have_resp_nxt;
    logic                 vfail, vfail_nxt;
    logic                 fail_nxt, busy_nxt, done_nxt;
    logic                 scan_en_nxt, scan_in_nxt, chain_ce_nxt;
    logic [CNT_W-1:0]     pat_count_nxt, fail_count_nxt;
    logic                 mismatch, vfail_any;

    // Ready is a pure decode of the state register, so it is glitch-free.
    assign pat_ready = (state == S_FETCH);

    // State, datapath and registered chain controls.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            stim_sr    <= '0;
            exp_cur    <= '0;
            exp_prev   <= '0;
            last       <= 1'b0;
            have_resp  <= 1'b0;
            vfail      <= 1'b0;
            fail       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
            chain_ce   <= 1'b0;
            pat_count  <= '0;
            fail_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            stim_sr    <= stim_nxt;
            exp_cur    <= exp_cur_nxt;
            exp_prev   <= exp_prev_nxt;
            last       <= last_nxt;
            have_resp  <= have_resp_nxt;
            vfail      <= vfail_nxt;
            fail       <= fail_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            scan_en    <= scan_en_nxt;
            scan_in    <= scan_in_nxt;
            chain_ce   <= chain_ce_nxt;
            pat_count  <= pat_count_nxt;
            fail_count <= fail_count_nxt;
        end
    end

    // Next-state logic; chain controls are computed for the cycle being entered
    // so that they come straight out of flops.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        stim_nxt       = stim_sr;
        exp_cur_nxt    = exp_cur;
        exp_prev_nxt   = exp_prev;
        last_nxt       = last;
        have_resp_nxt  = have_resp;
        vfail_nxt      = vfail;
        fail_nxt       = fail;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        scan_en_nxt    = scan_en;
        scan_in_nxt    = scan_in;
        chain_ce_nxt   = chain_ce;
        pat_count_nxt  = pat_count;
        fail_count_nxt = fail_count;
        mismatch       = 1'b0;
        vfail_any      = 1'b0;

        case (state)
            S_IDLE: begin
                scan_en_nxt  = 1'b0;
                scan_in_nxt  = 1'b0;
                chain_ce_nxt = 1'b0;
                if (start) begin
                    state_nxt      = S_FETCH;
                    fail_nxt       = 1'b0;
                    pat_count_nxt  = '0;
                    fail_count_nxt = '0;
                    have_resp_nxt  = 1'b0;
                    vfail_nxt      = 1'b0;
                    busy_nxt       = 1'b1;
                end
            end

            S_FETCH: begin
                if (pat_valid) begin
                    stim_nxt     = pat_data;
                    exp_prev_nxt = exp_cur;
                    exp_cur_nxt  = exp_data;
                    last_nxt     = pat_last;
                    cnt_nxt      = SHIFT_LOAD;
                    state_nxt    = S_SHIFT;
                    scan_en_nxt  = 1'b1;
                    chain_ce_nxt = 1'b1;
                    scan_in_nxt  = pat_data[CHAIN_LEN-1];
                end
            end

            S_SHIFT: begin
                // Stimulus and expected response both walk MSB first.
                mismatch     = have_resp && (scan_out != exp_prev[CHAIN_LEN-1]);
                vfail_any    = vfail | mismatch;
                stim_nxt     = stim_sr << 1;
                exp_prev_nxt = exp_prev << 1;
                if (cnt == '0) begin
                    if (vfail_any) begin
                        fail_nxt = 1'b1;
                        if (fail_count != CNT_MAX)
                            fail_count_nxt = fail_count + CTR_ONE;
                    end
                    vfail_nxt   = 1'b0;
                    cnt_nxt     = CAP_LOAD;
                    state_nxt   = S_CAPTURE;
                    scan_en_nxt = 1'b0;
                    scan_in_nxt = 1'b0;
                end else begin
                    vfail_nxt   = vfail_any;
                    cnt_nxt     = cnt - CNT_ONE;
                    scan_in_nxt = stim_sr[CHAIN_LEN-2];
                end
            end

            S_CAPTURE: begin
                if (cnt == '0) begin
                    pat_count_nxt = pat_count + CTR_ONE;
                    have_resp_nxt = 1'b1;
                    if (last) begin
                        state_nxt    = S_UNLOAD;
                        cnt_nxt      = SHIFT_LOAD;
                        scan_en_nxt  = 1'b1;
                        chain_ce_nxt = 1'b1;
                        scan_in_nxt  = 1'b0;
                    end else begin
                        state_nxt    = S_FETCH;
                        scan_en_nxt  = 1'b0;
                        chain_ce_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            S_UNLOAD: begin
                mismatch    = (scan_out != exp_cur[CHAIN_LEN-1]);
                vfail_any   = vfail | mismatch;
                exp_cur_nxt = exp_cur << 1;
                scan_in_nxt = 1'b0;
                if (cnt == '0) begin
                    if (vfail_any) begin
                        fail_nxt = 1'b1;
                        if (fail_count != CNT_MAX)
                            fail_count_nxt = fail_count + CTR_ONE;
                    end
                    vfail_nxt    = 1'b0;
                    state_nxt    = S_DONE;
                    done_nxt     = 1'b1;
                    scan_en_nxt  = 1'b0;
                    chain_ce_nxt = 1'b0;
                end else begin
                    vfail_nxt = vfail_any;
                    cnt_nxt   = cnt - CNT_ONE;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Randomized and directed bench for scan_test_ctrl with a behavioural chain.
module tb_scan_test_ctrl;

    localparam int L    = 5;
    localparam int CAP  = 1;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          pat_valid = 1'b0;
    logic          pat_last = 1'b0;
    logic [L-1:0]  pat_data = '0;
    logic [L-1:0]  exp_data = '0;
    logic          pat_ready, scan_en, scan_in, chain_ce, scan_out;
    logic          busy, done, fail;
    logic [CW-1:0] pat_count, fail_count;

    logic [L-1:0]  chain = '0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [CW-1:0] pc;
        logic [CW-1:0] fc;
        logic          f;
    } run_t;

    run_t        run_q[$];
    logic [1:0]  ops_q[$];
    logic [L-1:0] v_stim[$];
    logic [L-1:0] v_exp[$];
    int          v_stall[$];

    logic [1:0]  mon_code, mon_exp;
    run_t        mon_run;

    always #5 CK = ~CK;

    scan_test_ctrl #(.CHAIN_LEN(L), .CAP_CYCLES(CAP), .CNT_W(CW)) dut (
        .CK(CK), .RST(RST), .start(start),
        .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_data(pat_data), .exp_data(exp_data), .pat_last(pat_last),
        .scan_en(scan_en), .scan_in(scan_in), .chain_ce(chain_ce),
        .scan_out(scan_out), .busy(busy), .done(done), .fail(fail),
        .pat_count(pat_count), .fail_count(fail_count)
    );

    // Functional logic seen by the chain during capture.
    function automatic logic [L-1:0] cap_fn(input logic [L-1:0] x);
        return {x[L-2:0], x[L-1]} ^ ~(x >> 1);
    endfunction

    function automatic logic [L-1:0] resp_of(input logic [L-1:0] s);
        logic [L-1:0] r;
        r = s;
        repeat (CAP) r = cap_fn(r);
        return r;
    endfunction

    // Scan chain: head is chain[0], tail chain[L-1].
    assign scan_out = chain[L-1];
    always @(posedge CK) begin
        if (chain_ce) chain <= scan_en ? {chain[L-2:0], scan_in} : cap_fn(chain);
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every enabled chain cycle and every done pulse is scored.
    always @(negedge CK) begin
        if (!RST && chain_ce) begin
            mon_code = scan_en ? {1'b0, scan_in} : {1'b1, scan_in};
            if (ops_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL chain_op_unexpected: got code %0d expected none at %0t", mon_code, $time);
            end else begin
                mon_exp = ops_q.pop_front();
                check("chain_op", mon_code, mon_exp);
            end
        end
        if (!RST && done) begin
            done_cnt++;
            if (run_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got done pulse expected none at %0t", $time);
            end else begin
                mon_run = run_q.pop_front();
                check("pat_count", pat_count, mon_run.pc);
                check("fail_count", fail_count, mon_run.fc);
                check("fail", fail, mon_run.f);
            end
        end
    end

    task automatic clear_vecs();
        v_stim.delete();
        v_exp.delete();
        v_stall.delete();
    endtask

    task automatic add_vec(input logic [L-1:0] s, input bit corrupt, input int stall);
        logic [L-1:0] e;
        logic [L-1:0] m;
        e = resp_of(s);
        if (corrupt) begin
            m = '0;
            m[$urandom_range(0, L-1)] = 1'b1;
            e = e ^ m;
        end
        v_stim.push_back(s);
        v_exp.push_back(e);
        v_stall.push_back(stall);
    endtask

    task automatic wait_ready(output bit ok);
        int g;
        g = 0;
        while (!pat_ready && g < 200) begin
            @(negedge CK);
            g++;
        end
        ok = pat_ready;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got pat_ready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic pulse_start();
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
    endtask

    task automatic run_vectors(input bit mid_start);
        int   n, nbad, d0, g;
        bit   ok;
        run_t r;
        n = v_stim.size();
        nbad = 0;
        for (int i = 0; i < n; i++) begin
            if (v_exp[i] != resp_of(v_stim[i])) nbad++;
            for (int b = L - 1; b >= 0; b--) ops_q.push_back({1'b0, v_stim[i][b]});
            repeat (CAP) ops_q.push_back(2'b10);
        end
        repeat (L) ops_q.push_back(2'b00);
        r.pc = CW'(n % (1 << CW));
        r.fc = CW'((nbad > MAXC) ? MAXC : nbad);
        r.f  = (nbad > 0);
        run_q.push_back(r);
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < n; i++) begin
            wait_ready(ok);
            if (!ok) return;
            for (int s = 0; s < v_stall[i]; s++) begin
                check("stall_ready", pat_ready, 1);
                check("stall_chain_ce", chain_ce, 0);
                @(negedge CK);
            end
            pat_valid = 1'b1;
            pat_data  = v_stim[i];
            exp_data  = v_exp[i];
            pat_last  = (i == n - 1);
            @(posedge CK);
            #1;
            pat_valid = 1'b0;
            pat_last  = 1'b0;
            if (mid_start && i == 0) pulse_start();
        end
        g = 0;
        while (done_cnt == d0 && g < 1000) begin
            @(negedge CK);
            g++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected one within 1000 cycles");
        end
        @(negedge CK);
        check("busy_after_done", busy, 0);
        repeat (3) @(negedge CK);
    endtask

    initial begin
        logic [L-1:0] s;
        bit ok;

        // Reset state.
        #12;
        check("reset_outputs", {pat_ready, scan_en, scan_in, chain_ce, busy, done, fail,
                                pat_count, fail_count}, 0);
        @(negedge CK);
        RST = 1'b0;
        repeat (2) @(negedge CK);
        check("idle_ready", pat_ready, 0);

        // Single vector 10110, clean.
        clear_vecs();
        add_vec(5'b10110, 1'b0, 0);
        run_vectors(1'b0);

        // Three vectors, the second one with a wrong expected bit.
        clear_vecs();
        add_vec(L'($urandom), 1'b0, 0);
        add_vec(L'($urandom), 1'b1, 0);
        add_vec(L'($urandom), 1'b0, 0);
        run_vectors(1'b0);

        // Seven-cycle stall before the second vector.
        clear_vecs();
        add_vec(L'($urandom), 1'b0, 0);
        add_vec(L'($urandom), 1'b0, 7);
        add_vec(L'($urandom), 1'b0, 0);
        run_vectors(1'b0);

        // Reset on shift cycle k=2.
        s = 5'b01101;
        for (int b = L - 1; b >= L - 3; b--) ops_q.push_back({1'b0, s[b]});
        pulse_start();
        wait_ready(ok);
        pat_valid = 1'b1;
        pat_data  = s;
        exp_data  = resp_of(s);
        pat_last  = 1'b1;
        @(posedge CK);
        #1;
        pat_valid = 1'b0;
        pat_last  = 1'b0;
        repeat (3) @(negedge CK);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_outputs", {pat_ready, scan_en, scan_in, chain_ce, busy, done, fail,
                                    pat_count, fail_count}, 0);
        check("rst_shifts_seen", ops_q.size(), 0);
        ops_q.delete();
        repeat (2) @(negedge CK);
        RST = 1'b0;
        repeat (2) @(negedge CK);
        check("rst_stays_idle", busy, 0);
        clear_vecs();
        add_vec(L'($urandom), 1'b0, 0);
        run_vectors(1'b0);

        // Saturation: five failing vectors.
        clear_vecs();
        for (int i = 0; i < 5; i++) add_vec(L'($urandom), 1'b1, 0);
        run_vectors(1'b0);

        // Start pulsed during shift has no effect.
        clear_vecs();
        for (int i = 0; i < 3; i++) add_vec(L'($urandom), 1'b0, 0);
        run_vectors(1'b1);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            clear_vecs();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                add_vec(L'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
            run_vectors($urandom_range(0, 1) == 1);
        end

        check("ops_drained", ops_q.size(), 0);
        check("runs_drained", run_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
